// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and sizing helpers for the systolic edge feeder.
package systolic_pkg;

    typedef enum logic {
        FEED_IDLE,
        FEED_STREAM
    } feeder_state_t;

    // Step/vector counters must reach DEPTH+N-1 (longest skewed tile).
    function automatic int cnt_w(input int depth, input int n);
        return $clog2(depth + n);
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Load port and array-edge port of the systolic skew feeder.
interface systolic_skew_feeder_if #(
    parameter int N  = 8,
    parameter int DW = 32
);
    logic                  load_valid_i;
    logic                  load_ready_o;
    logic [N*DW-1:0]       load_data_i;
    logic                  load_last_i;
    logic                  advance_i;
    logic [N-1:0][DW-1:0]  data_o;
    logic [N-1:0]          lane_valid_o;
    logic                  tile_start_o;
    logic                  tile_done_o;
    logic                  busy_o;

    modport master (
        output load_valid_i, load_data_i, load_last_i, advance_i,
        input  load_ready_o, data_o, lane_valid_o, tile_start_o, tile_done_o, busy_o
    );

    modport slave (
        input  load_valid_i, load_data_i, load_last_i, advance_i,
        output load_ready_o, data_o, lane_valid_o, tile_start_o, tile_done_o, busy_o
    );
endinterface

// File: rtl/systolic_skew_feeder_pingpong_ram.sv
// Two-bank vector store: one full-vector write port, one read address per lane.
module feeder_pingpong_ram #(
    parameter int N     = 8,
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic                  wr_bank_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [N*DW-1:0]       wr_data_i,
    input  logic                  rd_bank_i,
    input  logic [N-1:0][AW-1:0]  rd_addr_i,
    output logic [N-1:0][DW-1:0]  rd_data_o
);
    logic [N*DW-1:0] r_mem [2][DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_bank_i][wr_addr_i] <= wr_data_i;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_rd
        assign rd_data_o[gi] = r_mem[rd_bank_i][rd_addr_i[gi]][gi*DW +: DW];
    end
endmodule

// File: rtl/systolic_skew_feeder.sv
// Ping-pong tile buffer streaming operand vectors into one systolic-array edge
// with optional per-lane diagonal skew; loading overlaps streaming.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int SKEW_EN    = 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  flush_i,
    systolic_skew_feeder_if.slave bus
);
    localparam int CW   = cnt_w(DEPTH, N);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TAIL = (SKEW_EN != 0) ? N - 1 : 0;

    feeder_state_t                 r_state, w_state_nxt;
    logic [1:0]                    r_full;
    logic                          r_wr_bank, r_rd_bank;
    logic [CW-1:0]                 r_wcnt, r_t;
    logic [CW-1:0]                 r_len [2];
    logic [N-1:0][DATA_WIDTH-1:0]  r_data;
    logic [N-1:0]                  r_lane_valid;
    logic                          r_start, r_done;

    logic                          w_accept, w_close, w_fire, w_last_step;
    logic [CW-1:0]                 w_step, w_len_rd;
    logic [N-1:0]                  w_lane_ok;
    logic [N-1:0][AW-1:0]          w_rd_addr;
    logic [N-1:0][DATA_WIDTH-1:0]  w_rd_data, w_lane_data;

    assign w_accept    = bus.load_valid_i & bus.load_ready_o;
    assign w_close     = w_accept & (bus.load_last_i | (r_wcnt == CW'(DEPTH - 1)));
    assign w_fire      = bus.advance_i & ((r_state == FEED_STREAM) | r_full[r_rd_bank]);
    assign w_step      = (r_state == FEED_IDLE) ? '0 : r_t;
    assign w_len_rd    = r_len[r_rd_bank];
    assign w_last_step = (w_step == (w_len_rd + CW'(TAIL) - CW'(1)));

    // Lane i reads vector k = step - offset; outside [0, len) the lane is idle.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam int OFF = (SKEW_EN != 0) ? gi : 0;
        logic [CW-1:0] w_k;
        assign w_k             = w_step - CW'(OFF);
        assign w_lane_ok[gi]   = (w_step >= CW'(OFF)) && (w_k < w_len_rd);
        assign w_rd_addr[gi]   = w_k[AW-1:0];
        assign w_lane_data[gi] = w_lane_ok[gi] ? w_rd_data[gi] : '0;
    end

    feeder_pingpong_ram #(
        .N     (N),
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (w_accept & ~flush_i),
        .wr_bank_i (r_wr_bank),
        .wr_addr_i (r_wcnt[AW-1:0]),
        .wr_data_i (bus.load_data_i),
        .rd_bank_i (r_rd_bank),
        .rd_addr_i (w_rd_addr),
        .rd_data_o (w_rd_data)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= FEED_IDLE;
        end else if (flush_i) begin
            r_state <= FEED_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FEED_IDLE:   if (w_fire && !w_last_step) w_state_nxt = FEED_STREAM;
            FEED_STREAM: if (w_fire && w_last_step)  w_state_nxt = FEED_IDLE;
            default:     w_state_nxt = FEED_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_full       <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_wcnt       <= '0;
            r_t          <= '0;
            r_len[0]     <= '0;
            r_len[1]     <= '0;
            r_data       <= '0;
            r_lane_valid <= '0;
            r_start      <= 1'b0;
            r_done       <= 1'b0;
        end else if (flush_i) begin
            r_full       <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_wcnt       <= '0;
            r_t          <= '0;
            r_data       <= '0;
            r_lane_valid <= '0;
            r_start      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if (w_close) begin
                r_len[r_wr_bank]  <= r_wcnt + CW'(1);
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
                r_wcnt            <= '0;
            end else if (w_accept) begin
                r_wcnt <= r_wcnt + CW'(1);
            end

            // The read bank is always full here, so it never collides with the write bank.
            if (w_fire) begin
                r_data       <= w_lane_data;
                r_lane_valid <= w_lane_ok;
                r_start      <= (r_state == FEED_IDLE);
                r_done       <= w_last_step;
                if (w_last_step) begin
                    r_full[r_rd_bank] <= 1'b0;
                    r_rd_bank         <= ~r_rd_bank;
                    r_t               <= '0;
                end else begin
                    r_t <= w_step + CW'(1);
                end
            end else if (r_state == FEED_IDLE) begin
                r_data       <= '0;
                r_lane_valid <= '0;
                r_start      <= 1'b0;
                r_done       <= 1'b0;
            end else begin
                r_start <= 1'b0;
                r_done  <= 1'b0;
            end
        end
    end

    assign bus.load_ready_o = ~r_full[r_wr_bank];
    assign bus.data_o       = r_data;
    assign bus.lane_valid_o = r_lane_valid;
    assign bus.tile_start_o = r_start;
    assign bus.tile_done_o  = r_done;
    assign bus.busy_o       = (r_state == FEED_STREAM) | (|r_full);
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Skewed and aligned feeders driven by identical stimulus, each checked against a tile-queue model.
module tb_systolic_skew_feeder;
    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [DEPTH-1:0][N*DW-1:0] v;
        logic [7:0]                 len;
    } tile_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.N(N), .DW(DW)) if_s ();
    systolic_skew_feeder_if #(.N(N), .DW(DW)) if_a ();

    systolic_skew_feeder #(.N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SKEW_EN(1)) u_skew (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .bus(if_s.slave));
    systolic_skew_feeder #(.N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SKEW_EN(0)) u_algn (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .bus(if_a.slave));

    int checks = 0;
    int errors = 0;

    // Model: queue of closed tiles per DUT (index 0 skewed, 1 aligned).
    tile_t                tq [2][$];
    tile_t                bld [2];
    int                   bcnt [2];
    bit                   strm [2];
    int                   mt [2];
    logic [N-1:0][DW-1:0] e_data [2];
    logic [N-1:0]         e_val [2];
    bit                   e_start [2];
    bit                   e_done [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            tq[d].delete();
            bld[d]     = '0;
            bcnt[d]    = 0;
            strm[d]    = 1'b0;
            mt[d]      = 0;
            e_data[d]  = '0;
            e_val[d]   = '0;
            e_start[d] = 1'b0;
            e_done[d]  = 1'b0;
        end
    endtask

    task automatic step_model(input int d, input bit v, input bit last,
                              input logic [N*DW-1:0] data, input bit adv, input bit fl);
        bit    rdy;
        tile_t cur;
        int    step, s_len, k, off;
        if (fl) begin
            tq[d].delete();
            bcnt[d] = 0; strm[d] = 0; mt[d] = 0;
            e_data[d] = '0; e_val[d] = '0; e_start[d] = 0; e_done[d] = 0;
            return;
        end
        rdy = (tq[d].size() < 2);
        if (adv && (strm[d] || tq[d].size() > 0)) begin
            cur   = tq[d][0];
            step  = strm[d] ? mt[d] : 0;
            s_len = int'(cur.len) + ((d == 0) ? N - 1 : 0);
            for (int i = 0; i < N; i++) begin
                off = (d == 0) ? i : 0;
                k   = step - off;
                if (k >= 0 && k < int'(cur.len)) begin
                    e_data[d][i] = cur.v[k][i*DW +: DW];
                    e_val[d][i]  = 1'b1;
                end else begin
                    e_data[d][i] = '0;
                    e_val[d][i]  = 1'b0;
                end
            end
            e_start[d] = !strm[d];
            e_done[d]  = (step == s_len - 1);
            if (e_done[d]) begin
                void'(tq[d].pop_front());
                strm[d] = 0;
            end else begin
                strm[d] = 1;
                mt[d]   = step + 1;
            end
        end else if (!strm[d]) begin
            e_data[d] = '0; e_val[d] = '0; e_start[d] = 0; e_done[d] = 0;
        end else begin
            e_start[d] = 0; e_done[d] = 0;
        end
        if (v && rdy) begin
            bld[d].v[bcnt[d]] = data;
            bcnt[d]++;
            if (last || bcnt[d] == DEPTH) begin
                bld[d].len = 8'(bcnt[d]);
                tq[d].push_back(bld[d]);
                bld[d]  = '0;
                bcnt[d] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("s_data",  if_s.data_o,       e_data[0]);
        chk("s_valid", if_s.lane_valid_o, e_val[0]);
        chk("s_start", if_s.tile_start_o, e_start[0]);
        chk("s_done",  if_s.tile_done_o,  e_done[0]);
        chk("s_busy",  if_s.busy_o,       strm[0] || tq[0].size() > 0);
        chk("a_data",  if_a.data_o,       e_data[1]);
        chk("a_valid", if_a.lane_valid_o, e_val[1]);
        chk("a_start", if_a.tile_start_o, e_start[1]);
        chk("a_done",  if_a.tile_done_o,  e_done[1]);
        chk("a_busy",  if_a.busy_o,       strm[1] || tq[1].size() > 0);
    endtask

    task automatic cyc(input bit v, input bit last, input logic [N*DW-1:0] data,
                       input bit adv, input bit fl);
        @(negedge clk);
        if_s.load_valid_i = v;   if_a.load_valid_i = v;
        if_s.load_last_i  = last; if_a.load_last_i = last;
        if_s.load_data_i  = data; if_a.load_data_i = data;
        if_s.advance_i    = adv;  if_a.advance_i   = adv;
        flush = fl;
        #1;
        chk("s_ready", if_s.load_ready_o, tq[0].size() < 2);
        chk("a_ready", if_a.load_ready_o, tq[1].size() < 2);
        @(posedge clk);
        step_model(0, v, last, data, adv, fl);
        step_model(1, v, last, data, adv, fl);
        #1;
        check_outputs();
    endtask

    function automatic logic [N*DW-1:0] vec(input int k);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(16 * k + i);
        return r;
    endfunction

    function automatic logic [N*DW-1:0] rnd_vec();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        if_s.load_valid_i = 0; if_a.load_valid_i = 0;
        if_s.load_last_i  = 0; if_a.load_last_i  = 0;
        if_s.load_data_i  = '0; if_a.load_data_i = '0;
        if_s.advance_i    = 0; if_a.advance_i    = 0;
        model_reset();
        #12;
        check_outputs();
        chk("rst_s_ready", if_s.load_ready_o, 1'b1);
        chk("rst_a_ready", if_a.load_ready_o, 1'b1);
        @(negedge clk);
        rstn = 1'b1;

        // Tile of 3 vectors, then stream continuously.
        for (int k = 0; k < 3; k++) cyc(1, k == 2, vec(k), 0, 0);
        for (int c = 0; c < 8; c++) begin
            cyc(0, 0, '0, 1, 0);
            if (c == 3) chk("t1_lane2_step3", 64'(if_s.data_o[2]), 64'h12);
        end

        // Back-to-back tiles of 2 vectors with continuous advance.
        for (int c = 0; c < 6; c++) cyc(1, c % 2 == 1, rnd_vec(), 1, 0);
        for (int c = 0; c < 14; c++) cyc(0, 0, '0, 1, 0);

        // Stall for two cycles mid-tile.
        for (int k = 0; k < 3; k++) cyc(1, k == 2, vec(k), 0, 0);
        for (int c = 0; c < 10; c++) cyc(0, 0, '0, !(c == 3 || c == 4), 0);

        // Five vectors, last only on the fifth: auto-close at DEPTH.
        for (int k = 0; k < 5; k++) cyc(1, k == 4, vec(k), 0, 0);
        for (int c = 0; c < 12; c++) cyc(0, 0, '0, 1, 0);

        // Async reset mid-stream.
        for (int k = 0; k < 3; k++) cyc(1, k == 2, vec(k), 0, 0);
        for (int c = 0; c < 3; c++) cyc(0, 0, '0, 1, 0);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("arst_s_ready", if_s.load_ready_o, 1'b1);
        chk("arst_a_ready", if_a.load_ready_o, 1'b1);
        @(negedge clk);
        rstn = 1'b1;

        // Flush mid-stream, with a competing load and advance.
        for (int k = 0; k < 3; k++) cyc(1, k == 2, vec(k), 0, 0);
        for (int c = 0; c < 3; c++) cyc(0, 0, '0, 1, 0);
        cyc(1, 1, vec(7), 1, 1);
        for (int c = 0; c < 4; c++) cyc(0, 0, '0, 1, 0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, rnd_vec(),
                $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
        end
        for (int c = 0; c < 30; c++) cyc(0, 0, '0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
